can_write_channel: RTL and testbench

Write channel of the CAN controller Microcontroller Interface. It accepts one register write at a time from rtc_mc_if, checks the address against the writable register map, and drives a one-hot register select, data and a single-cycle write strobe to the register file. It then waits for the register file's acknowledge and reports completion or error back to rtc_mc_if. It is the write-direction counterpart of can_read_channel.

---
 rtl/can_mc_if_pkg.sv | 40 ++++
 rtl/can_write_channel_if.sv | 37 +++
 rtl/can_wr_addr_decoder.sv | 25 ++
 rtl/can_write_channel.sv | 139 +++++++++++++
 tb/tb_can_write_channel.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/can_mc_if_pkg.sv
// ----------------------------------------------------------------------------
// can_mc_if_pkg
// Shared types and constants for the CAN controller microcontroller interface:
// write FSM state encoding, writable register map, bus widths and the bit
// positions inside the sticky error status.
// ----------------------------------------------------------------------------
package can_mc_if_pkg;

   localparam int unsigned ADDR_W      = 6;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned BE_W        = 4;
   localparam int unsigned NUM_WR_REGS = 20;
   localparam int unsigned ERR_W       = 2;
   localparam int unsigned TO_CNT_W    = 8;

   // Error status bit positions
   localparam int unsigned ERR_BIT_ADDR    = 0;
   localparam int unsigned ERR_BIT_TIMEOUT = 1;

   // Writable map; 0x02 (status) and 0x03 (interrupt) are read-only
   localparam logic [ADDR_W-1:0] WR_ADDR_CTRL   = 6'h00;
   localparam logic [ADDR_W-1:0] WR_ADDR_CMD    = 6'h01;
   localparam logic [ADDR_W-1:0] WR_ADDR_BLK_LO = 6'h04;
   localparam logic [ADDR_W-1:0] WR_ADDR_BLK_HI = 6'h13;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STROBE   = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_DONE     = 3'd3,
      ST_ERR      = 3'd4
   } wr_state_e;

   // True when the address may be written by the microcontroller
   function automatic logic is_wr_addr(input logic [ADDR_W-1:0] addr);
      return (addr == WR_ADDR_CTRL) || (addr == WR_ADDR_CMD) ||
             ((addr >= WR_ADDR_BLK_LO) && (addr <= WR_ADDR_BLK_HI));
   endfunction

endpackage

// File: rtl/can_write_channel_if.sv
// ----------------------------------------------------------------------------
// can_write_channel_if
// Write-channel bundle between rtc_mc_if (request side), the write channel and
// the register file (select/data/strobe/ack side).
//   slave  : the write channel (consumes i_*, drives o_*)
//   master : requester / register file model (drives i_*, observes o_*)
// ----------------------------------------------------------------------------
interface can_write_channel_if;
   import can_mc_if_pkg::*;

   logic                   i_wr_en;
   logic [ADDR_W-1:0]      i_addr;
   logic [DATA_W-1:0]      i_wr_data;
   logic [BE_W-1:0]        i_byte_en;
   logic                   i_ack;
   logic                   i_err_clr;
   logic                   o_busy;
   logic [NUM_WR_REGS-1:0] o_wr_dec_addr;
   logic [DATA_W-1:0]      o_reg_w_data;
   logic [BE_W-1:0]        o_byte_en;
   logic                   o_wr_strobe;
   logic                   o_done;
   logic                   o_err;
   logic [ERR_W-1:0]       o_err_status;

   modport slave (
      input  i_wr_en, i_addr, i_wr_data, i_byte_en, i_ack, i_err_clr,
      output o_busy, o_wr_dec_addr, o_reg_w_data, o_byte_en, o_wr_strobe,
             o_done, o_err, o_err_status
   );

   modport master (
      output i_wr_en, i_addr, i_wr_data, i_byte_en, i_ack, i_err_clr,
      input  o_busy, o_wr_dec_addr, o_reg_w_data, o_byte_en, o_wr_strobe,
             o_done, o_err, o_err_status
   );
endinterface

// File: rtl/can_wr_addr_decoder.sv
// ----------------------------------------------------------------------------
// can_wr_addr_decoder
// Combinational decode of a register address into a one-hot write select.
//   addr       in  6   register address
//   sel_c      out 20  one-hot select, bit n = address n (all-zero if not writable)
//   writable_c out 1   address is in the writable map
// ----------------------------------------------------------------------------
module can_wr_addr_decoder
   import can_mc_if_pkg::*;
(
   input  logic [ADDR_W-1:0]      addr,
   output logic [NUM_WR_REGS-1:0] sel_c,
   output logic                   writable_c
);

   // Read-only and out-of-range addresses produce no select bit
   always_comb begin
      writable_c = is_wr_addr(addr);
      sel_c      = '0;
      for (int unsigned n = 0; n < NUM_WR_REGS; n++) begin
         sel_c[n] = writable_c && (addr == ADDR_W'(n));
      end
   end

endmodule

// File: rtl/can_write_channel.sv
// ----------------------------------------------------------------------------
// can_write_channel
// Accepts one register write at a time, validates it against the writable map,
// issues a one-cycle strobe with one-hot select/data/byte enables to the
// register file, waits for its ack and reports done or error.
// Ports:
//   i_clk    in  clock, rising edge
//   i_reset  in  synchronous active-high reset
//   bus      slave modport of can_write_channel_if (request, register file
//            and status signals; all outputs registered)
// Parameter:
//   ACK_TIMEOUT  WAIT_ACK cycles before a timeout error (1..255)
// Build option:
//   CAN_WR_TIMEOUT_EN  when defined, builds the ack timeout counter and
//                      o_err_status[1]; otherwise WAIT_ACK waits forever.
// ----------------------------------------------------------------------------
module can_write_channel
   import can_mc_if_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic                i_clk,
   input  logic                i_reset,
   can_write_channel_if.slave  bus
);

   if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > (2 ** TO_CNT_W) - 1)) begin : g_bad_ack_timeout
      $error("ACK_TIMEOUT must be in 1..255");
   end

   wr_state_e              state;
   logic [NUM_WR_REGS-1:0] dec_sel_c;
   logic                   dec_writable_c;

`ifdef CAN_WR_TIMEOUT_EN
   // Compare against count-1: the counter value seen in the last WAIT_ACK cycle
   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(ACK_TIMEOUT - 1);
   logic [TO_CNT_W-1:0] to_cnt;
`endif

   // Decoded select is captured into o_wr_dec_addr on acceptance
   can_wr_addr_decoder u_dec (
      .addr       (bus.i_addr),
      .sel_c      (dec_sel_c),
      .writable_c (dec_writable_c)
   );

   // Write FSM with registered outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state              <= ST_IDLE;
         bus.o_busy         <= 1'b0;
         bus.o_wr_dec_addr  <= '0;
         bus.o_reg_w_data   <= '0;
         bus.o_byte_en      <= '0;
         bus.o_wr_strobe    <= 1'b0;
         bus.o_done         <= 1'b0;
         bus.o_err          <= 1'b0;
         bus.o_err_status   <= '0;
`ifdef CAN_WR_TIMEOUT_EN
         to_cnt             <= '0;
`endif
      end else begin
         bus.o_wr_strobe <= 1'b0;
         bus.o_done      <= 1'b0;
         bus.o_err       <= 1'b0;
         // Clear first so that a set later in this block wins
         if (bus.i_err_clr) begin
            bus.o_err_status <= '0;
         end
`ifndef CAN_WR_TIMEOUT_EN
         bus.o_err_status[ERR_BIT_TIMEOUT] <= 1'b0;
`endif

         case (state)
            ST_IDLE: begin
               if (bus.i_wr_en) begin
                  bus.o_reg_w_data <= bus.i_wr_data;
                  bus.o_byte_en    <= bus.i_byte_en;
                  bus.o_busy       <= 1'b1;
                  if (dec_writable_c && (bus.i_byte_en != '0)) begin
                     state             <= ST_STROBE;
                     bus.o_wr_strobe   <= 1'b1;
                     bus.o_wr_dec_addr <= dec_sel_c;
                  end else begin
                     state                          <= ST_ERR;
                     bus.o_err                      <= 1'b1;
                     bus.o_err_status[ERR_BIT_ADDR] <= 1'b1;
                  end
               end
            end

            ST_STROBE: begin
               if (bus.i_ack) begin
                  state             <= ST_DONE;
                  bus.o_done        <= 1'b1;
                  bus.o_wr_dec_addr <= '0;
               end else begin
                  state <= ST_WAIT_ACK;
`ifdef CAN_WR_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end
            end

            ST_WAIT_ACK: begin
               // Ack takes priority over a coincident timeout
               if (bus.i_ack) begin
                  state             <= ST_DONE;
                  bus.o_done        <= 1'b1;
                  bus.o_wr_dec_addr <= '0;
               end
`ifdef CAN_WR_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  state                             <= ST_ERR;
                  bus.o_err                         <= 1'b1;
                  bus.o_wr_dec_addr                 <= '0;
                  bus.o_err_status[ERR_BIT_TIMEOUT] <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_CNT_W'(1);
               end
`endif
            end

            ST_DONE, ST_ERR: begin
               state      <= ST_IDLE;
               bus.o_busy <= 1'b0;
            end

            default: begin
               state             <= ST_IDLE;
               bus.o_busy        <= 1'b0;
               bus.o_wr_dec_addr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_can_write_channel.sv
// ----------------------------------------------------------------------------
// tb_can_write_channel
// Self-checking bench for can_write_channel: a vector table of single writes
// with cycle-exact checks, a scoreboard of expected completions, and hand
// sequences for set/clear priority, busy-time requests, ack timeout and reset
// during a transaction.
// ----------------------------------------------------------------------------
module tb_can_write_channel;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   can_write_channel_if bus ();

   can_write_channel dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          ack_dly;   // cycles after the strobe cycle until ack
      bit          ok;        // expected to complete successfully
      logic [19:0] sel;       // expected one-hot select
      bit          poke;      // re-request addr 0x07 while busy
   } vec_t;

   typedef struct {
      bit          ok;
      logic [31:0] data;
   } exp_t;

   vec_t vecs[12];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},   32'(bus.o_busy),        32'h0);
      check({tag, "_sel"},    32'(bus.o_wr_dec_addr), 32'h0);
      check({tag, "_data"},   bus.o_reg_w_data,       32'h0);
      check({tag, "_be"},     32'(bus.o_byte_en),     32'h0);
      check({tag, "_strobe"}, 32'(bus.o_wr_strobe),   32'h0);
      check({tag, "_done"},   32'(bus.o_done),        32'h0);
      check({tag, "_err"},    32'(bus.o_err),         32'h0);
      check({tag, "_status"}, 32'(bus.o_err_status),  32'h0);
   endtask

   // Scoreboard: every done/err pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (!rst && (bus.o_done || bus.o_err)) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_completion", 32'({bus.o_done, bus.o_err}), 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_kind", 32'({bus.o_done, bus.o_err}), e.ok ? 32'h2 : 32'h1);
            if (e.ok) check("sb_data", bus.o_reg_w_data, e.data);
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at a negedge with it idle
   task automatic run_vec(input vec_t v, input string tag);
      bus.i_wr_en   = 1'b1;
      bus.i_addr    = v.addr;
      bus.i_wr_data = v.data;
      bus.i_byte_en = v.be;
      sb.push_back('{ok: v.ok, data: v.data});
      @(negedge clk);                                   // cycle 1
      bus.i_wr_en = v.poke;
      if (v.poke) begin
         bus.i_addr    = 6'h07;
         bus.i_wr_data = 32'hFFFF_FFFF;
         bus.i_byte_en = 4'hF;
      end
      check({tag, "_busy1"}, 32'(bus.o_busy), 32'h1);
      if (!v.ok) begin
         check({tag, "_nostrobe"}, 32'(bus.o_wr_strobe),  32'h0);
         check({tag, "_nosel"},    32'(bus.o_wr_dec_addr), 32'h0);
         check({tag, "_err1"},     32'(bus.o_err),        32'h1);
         check({tag, "_status1"},  32'(bus.o_err_status), 32'h1);
         @(negedge clk);                                // cycle 2
         check({tag, "_idle2"}, 32'(bus.o_busy), 32'h0);
         check({tag, "_err2"},  32'(bus.o_err),  32'h0);
         bus.i_err_clr = 1'b1;
         @(negedge clk);
         bus.i_err_clr = 1'b0;
         check({tag, "_cleared"}, 32'(bus.o_err_status), 32'h0);
      end else begin
         check({tag, "_strobe1"}, 32'(bus.o_wr_strobe),   32'h1);
         check({tag, "_sel1"},    32'(bus.o_wr_dec_addr), 32'(v.sel));
         check({tag, "_data1"},   bus.o_reg_w_data,       v.data);
         check({tag, "_be1"},     32'(bus.o_byte_en),     32'(v.be));
         for (int c = 1; c <= 1 + v.ack_dly; c++) begin
            if (c > 1) begin
               @(negedge clk);
               check({tag, "_wait_strobe"}, 32'(bus.o_wr_strobe),   32'h0);
               check({tag, "_wait_sel"},    32'(bus.o_wr_dec_addr), 32'(v.sel));
               check({tag, "_wait_data"},   bus.o_reg_w_data,       v.data);
               check({tag, "_wait_done"},   32'(bus.o_done | bus.o_err), 32'h0);
            end
            bus.i_ack = (c == 1 + v.ack_dly);
         end
         @(negedge clk);                                // DONE cycle
         bus.i_ack   = 1'b0;
         bus.i_wr_en = 1'b0;
         check({tag, "_done"},     32'(bus.o_done),        32'h1);
         check({tag, "_done_sel"}, 32'(bus.o_wr_dec_addr), 32'h0);
         check({tag, "_done_bsy"}, 32'(bus.o_busy),        32'h1);
         @(negedge clk);                                // back in IDLE
         check({tag, "_idle"},   32'(bus.o_busy),       32'h0);
         check({tag, "_status"}, 32'(bus.o_err_status), 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      vecs[0]  = '{6'h05, 32'hDEAD_BEEF, 4'hF, 0,  1'b1, 20'h00020, 1'b0};
      vecs[1]  = '{6'h02, 32'h1111_1111, 4'hF, 0,  1'b0, 20'h00000, 1'b0};
      vecs[2]  = '{6'h13, 32'h1234_5678, 4'h3, 4,  1'b1, 20'h80000, 1'b0};
      vecs[3]  = '{6'h00, 32'hA5A5_A5A5, 4'h1, 1,  1'b1, 20'h00001, 1'b0};
      vecs[4]  = '{6'h01, 32'h0F0F_0F0F, 4'h8, 2,  1'b1, 20'h00002, 1'b0};
      vecs[5]  = '{6'h03, 32'h2222_2222, 4'hF, 0,  1'b0, 20'h00000, 1'b0};
      vecs[6]  = '{6'h14, 32'h3333_3333, 4'hF, 0,  1'b0, 20'h00000, 1'b0};
      vecs[7]  = '{6'h3F, 32'h4444_4444, 4'hF, 0,  1'b0, 20'h00000, 1'b0};
      vecs[8]  = '{6'h04, 32'h5555_5555, 4'h0, 0,  1'b0, 20'h00000, 1'b0};
      vecs[9]  = '{6'h04, 32'h6666_6666, 4'hC, 0,  1'b1, 20'h00010, 1'b0};
      vecs[10] = '{6'h08, 32'h7777_7777, 4'hF, 15, 1'b1, 20'h00100, 1'b0};
      vecs[11] = '{6'h05, 32'h1122_3344, 4'hF, 3,  1'b1, 20'h00020, 1'b1};

      rst           = 1'b1;
      bus.i_wr_en   = 1'b0;
      bus.i_addr    = '0;
      bus.i_wr_data = '0;
      bus.i_byte_en = '0;
      bus.i_ack     = 1'b0;
      bus.i_err_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Ack while idle is ignored
      bus.i_ack = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ack_busy", 32'(bus.o_busy), 32'h0);
      check("idle_ack_done", 32'(bus.o_done), 32'h0);
      bus.i_ack = 1'b0;

      // Error set and clear in the same cycle: set wins
      bus.i_err_clr = 1'b1;
      bus.i_wr_en   = 1'b1;
      bus.i_addr    = 6'h02;
      bus.i_byte_en = 4'hF;
      sb.push_back('{ok: 1'b0, data: 32'h0});
      @(negedge clk);
      bus.i_wr_en = 1'b0;
      check("setwins_status", 32'(bus.o_err_status), 32'h1);
      check("setwins_err",    32'(bus.o_err),        32'h1);
      @(negedge clk);
      bus.i_err_clr = 1'b0;
      check("setwins_cleared", 32'(bus.o_err_status), 32'h0);
      check("setwins_idle",    32'(bus.o_busy),       32'h0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // No ack at all
      bus.i_wr_en   = 1'b1;
      bus.i_addr    = 6'h00;
      bus.i_wr_data = 32'h0000_0001;
      bus.i_byte_en = 4'hF;
`ifdef CAN_WR_TIMEOUT_EN
      sb.push_back('{ok: 1'b0, data: 32'h0000_0001});
      @(negedge clk);                                   // cycle 1 (STROBE)
      bus.i_wr_en = 1'b0;
      check("to_strobe", 32'(bus.o_wr_strobe), 32'h1);
      for (int c = 2; c <= 16; c++) begin
         @(negedge clk);
         check("to_wait_err", 32'(bus.o_err),         32'h0);
         check("to_wait_sel", 32'(bus.o_wr_dec_addr), 32'h1);
      end
      @(negedge clk);                                   // cycle 17
      check("to_err",    32'(bus.o_err),         32'h1);
      check("to_status", 32'(bus.o_err_status),  32'h2);
      check("to_sel",    32'(bus.o_wr_dec_addr), 32'h0);
      @(negedge clk);
      check("to_idle", 32'(bus.o_busy), 32'h0);
      bus.i_err_clr = 1'b1;
      @(negedge clk);
      bus.i_err_clr = 1'b0;
      check("to_cleared", 32'(bus.o_err_status), 32'h0);
`else
      sb.push_back('{ok: 1'b1, data: 32'h0000_0001});
      @(negedge clk);                                   // cycle 1 (STROBE)
      bus.i_wr_en = 1'b0;
      check("noto_strobe", 32'(bus.o_wr_strobe), 32'h1);
      for (int c = 2; c <= 40; c++) begin
         @(negedge clk);
         check("noto_wait_busy", 32'(bus.o_busy),        32'h1);
         check("noto_wait_err",  32'(bus.o_err),         32'h0);
         check("noto_wait_sel",  32'(bus.o_wr_dec_addr), 32'h1);
      end
      bus.i_ack = 1'b1;
      @(negedge clk);
      bus.i_ack = 1'b0;
      check("noto_done",   32'(bus.o_done),       32'h1);
      check("noto_status", 32'(bus.o_err_status), 32'h0);
      @(negedge clk);
      check("noto_idle", 32'(bus.o_busy), 32'h0);
`endif

      // Reset during WAIT_ACK aborts the write with no completion pulse
      bus.i_wr_en   = 1'b1;
      bus.i_addr    = 6'h09;
      bus.i_wr_data = 32'hCAFE_F00D;
      bus.i_byte_en = 4'h6;
      sb.push_back('{ok: 1'b1, data: 32'hCAFE_F00D});
      @(negedge clk);                                   // cycle 1
      bus.i_wr_en = 1'b0;
      check("rst_strobe", 32'(bus.o_wr_strobe), 32'h1);
      @(negedge clk);                                   // cycle 2 (WAIT_ACK)
      check("rst_wait_sel", 32'(bus.o_wr_dec_addr), 32'h00200);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      check_all_zero("midrst");
      repeat (3) begin
         @(negedge clk);
         check("midrst_quiet", 32'({bus.o_busy, bus.o_done, bus.o_err}), 32'h0);
      end
      rv = '{6'h01, 32'h0BAD_CAFE, 4'hF, 0, 1'b1, 20'h00002, 1'b0};
      run_vec(rv, "post_rst");

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
